instr_enc_loader: RTL and testbench

Instruction encoder and instruction-memory loader. Accepts decoded instruction fields (opcode, registers, funct, signed byte-offset immediate) over a valid/ready stream, packs them into 32-bit words in the exact immediate layouts the decode stage unpacks, and writes them to consecutive instruction-memory addresses. Sits between the testbench/boot source and the instruction memory; it is the inverse of the ID-stage immediate generation.

---
 rtl/instr_enc_loader.sv | 198 +++++++++++++++++++
 tb/tb_instr_enc_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc_loader.sv
// Instruction encoder / imem loader: packs decoded fields into 32-bit words and
// streams them to consecutive instruction-memory addresses through a one-entry output register.
module instr_enc_loader #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(4);

  localparam logic [1:0] EC_OPCODE   = 2'b01;
  localparam logic [1:0] EC_RANGE    = 2'b10;
  localparam logic [1:0] EC_OVERFLOW = 2'b11;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              full;
  logic              stale;

  logic              wr_done;
  logic              accept;
  logic              own_pending;
  logic [ADDR_W-1:0] acc_addr;
  logic              overflow;
  logic [31:0]       enc_word;
  logic              bad_op;
  logic              bad_rng;
  logic              rng11;
  logic              rng13;
  logic              rng21;
  logic              align4;

  assign wr_done     = imem_we && imem_ready;
  assign in_ready    = (state == S_LOAD) && (!imem_we || imem_ready);
  assign accept      = in_valid && in_ready;
  assign busy        = (state == S_LOAD) || (state == S_DRAIN);

  // A write left over from a previous session must not move this session's pointer.
  assign own_pending = imem_we && !stale;
  assign acc_addr    = own_pending ? ptr + STEP : ptr;
  assign overflow    = full || (own_pending && (imem_addr == LAST_ADDR));

  assign rng11  = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign rng13  = (&in_imm[31:13]) || !(|in_imm[31:13]);
  assign rng21  = (&in_imm[31:21]) || !(|in_imm[31:21]);
  assign align4 = (in_imm[1:0] == 2'b00);

  always_comb begin
    enc_word = '0;
    bad_op   = 1'b0;
    bad_rng  = 1'b0;
    case (in_opcode)
      OP_R: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_LW: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad_rng  = !rng11;
      end
      OP_SW: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        bad_rng  = !rng11;
      end
      OP_B: begin
        enc_word = {in_imm[13], in_imm[11:6], in_rs2, in_rs1, in_funct3,
                    in_imm[5:2], in_imm[12], in_opcode};
        bad_rng  = !rng13 || !align4;
      end
      OP_JAL: begin
        enc_word = {in_imm[21], in_imm[11:2], in_imm[12], in_imm[20:13], in_rd, in_opcode};
        bad_rng  = !rng21 || !align4;
      end
      default: begin
        bad_op = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= BASE_ADDR;
      full       <= 1'b0;
      stale      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_addr   <= '0;
    end else begin
      if (wr_done) begin
        imem_we <= 1'b0;
        stale   <= 1'b0;
        if (!stale) begin
          ptr <= ptr + STEP;
          if (imem_addr == LAST_ADDR) begin
            full <= 1'b1;
          end
        end
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            ptr      <= BASE_ADDR;
            full     <= 1'b0;
            stale    <= imem_we && !imem_ready;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            err_addr <= '0;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (accept) begin
            // Error priority: opcode, then range, then overflow; any error wins over in_last.
            if (bad_op) begin
              err      <= 1'b1;
              err_code <= EC_OPCODE;
              err_addr <= acc_addr;
              state    <= S_ERR;
            end else if (bad_rng) begin
              err      <= 1'b1;
              err_code <= EC_RANGE;
              err_addr <= acc_addr;
              state    <= S_ERR;
            end else if (overflow) begin
              err      <= 1'b1;
              err_code <= EC_OVERFLOW;
              err_addr <= LAST_ADDR;
              state    <= S_ERR;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= acc_addr;
              imem_wdata <= enc_word;
              if (in_last) begin
                state <= S_DRAIN;
              end
            end
          end
        end

        S_DRAIN: begin
          if (!imem_we || wr_done) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed self-checking bench for instr_enc_loader: a 1 KiB instance and a
// 16-byte instance share all stimulus; the small one exercises overflow.
module tb_instr_enc_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        imem_ready = 1'b0;

  logic        in_ready, imem_we, busy, done, err;
  logic [9:0]  imem_addr, err_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;

  logic        s_in_ready, s_imem_we, s_busy, s_done, s_err;
  logic [3:0]  s_imem_addr, s_err_addr;
  logic [31:0] s_imem_wdata;
  logic [1:0]  s_err_code;

  int checks = 0;
  int failures = 0;

  int cap_addr[$];
  logic [31:0] cap_data[$];
  int s_cap_addr[$];

  always #5 clk = ~clk;

  instr_enc_loader #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .err_addr(err_addr)
  );

  instr_enc_loader #(.ADDR_W(4), .BASE_ADDR(4'd0)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .imem_we(s_imem_we), .imem_ready(imem_ready), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code), .err_addr(s_err_addr)
  );

  always @(posedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      cap_addr.push_back(int'(imem_addr));
      cap_data.push_back(imem_wdata);
      $display("write big   addr=%0d data=%08h", imem_addr, imem_wdata);
    end
    if (rst_n && s_imem_we && imem_ready) begin
      s_cap_addr.push_back(int'(s_imem_addr));
      $display("write small addr=%0d data=%08h", s_imem_addr, s_imem_wdata);
    end
  end

  // ID-stage immediate reconstruction for the B and JAL layouts.
  function automatic int dec_b(input logic [31:0] w);
    logic signed [13:0] t;
    t = {w[31], w[7], w[30:25], w[11:8], 2'b00};
    return int'(t);
  endfunction

  function automatic int dec_j(input logic [31:0] w);
    logic signed [21:0] t;
    t = {w[31], w[19:12], w[20], w[30:21], 2'b00};
    return int'(t);
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one bundle and returns at the negedge following its acceptance edge.
  task automatic push(input bit sel, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input bit last);
    bit ok;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if ((sel ? s_in_ready : in_ready) === 1'b1) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    $display("bundle op=%07b imm=%08h last=%0b accepted=%0b", op, imm, last, ok);
    if (!ok) begin
      failures++;
      $display("FAIL push_timeout: in_ready never high, required 1");
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_imem_we: got %b, required 0", imem_we); end
    checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL reset_imem_addr: got %0d, required 0", imem_addr); end
    checks++; if (imem_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata: got %08h, required 0", imem_wdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b, required 000", {busy, done, err}); end
    checks++; if (err_code !== 2'b00 || err_addr !== 10'd0) begin failures++; $display("FAIL reset_err_info: got %b/%0d, required 00/0", err_code, err_addr); end
  endtask

  task automatic test_basic();
    imem_ready = 1'b1;
    cap_addr.delete(); cap_data.delete();
    do_start();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL start_ready: got in_ready=%b busy=%b, required 1/1", in_ready, busy); end
    push(0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h002081B3) begin
      failures++; $display("FAIL r_out_reg: got we=%b addr=%0d data=%08h, required 1/0/002081b3", imem_we, imem_addr, imem_wdata); end
    push(0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd4, 1'b1);
    wait_done();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done: got done=%b busy=%b, required 1/0", done, busy); end
    checks++; if (cap_addr.size() != 2) begin failures++; $display("FAIL basic_count: got %0d writes, required 2", cap_addr.size()); end
    else begin
      checks++; if (cap_addr[0] != 0 || cap_data[0] !== 32'h002081B3) begin failures++; $display("FAIL basic_w0: got %0d/%08h, required 0/002081b3", cap_addr[0], cap_data[0]); end
      checks++; if (cap_addr[1] != 4 || cap_data[1] !== 32'hFFC12283) begin failures++; $display("FAIL basic_w1: got %0d/%08h, required 4/ffc12283", cap_addr[1], cap_data[1]); end
    end
  endtask

  task automatic test_branch_jal();
    cap_addr.delete(); cap_data.delete();
    do_start();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL start_clears_done: got %b, required 0", done); end
    push(0, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
    push(0, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8, 1'b1);
    wait_done();
    checks++; if (cap_data.size() != 2) begin failures++; $display("FAIL bj_count: got %0d writes, required 2", cap_data.size()); end
    else begin
      checks++; if (cap_data[0] !== 32'h00208263) begin failures++; $display("FAIL b_word: got %08h, required 00208263", cap_data[0]); end
      checks++; if (dec_b(cap_data[0]) != 8) begin failures++; $display("FAIL b_roundtrip: got %0d, required 8", dec_b(cap_data[0])); end
      checks++; if (cap_data[1] !== 32'hFFDFF0EF || cap_addr[1] != 4) begin failures++; $display("FAIL jal_word: got %08h@%0d, required ffdff0ef@4", cap_data[1], cap_addr[1]); end
      checks++; if (dec_j(cap_data[1]) != -8) begin failures++; $display("FAIL jal_roundtrip: got %0d, required -8", dec_j(cap_data[1])); end
    end
  endtask

  task automatic test_backpressure();
    cap_addr.delete(); cap_data.delete();
    imem_ready = 1'b0;
    do_start();
    push(0, 7'b0110011, 5'd7, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b0);
    in_opcode = 7'b0100011; in_rs1 = 5'd2; in_rs2 = 5'd9; in_funct3 = 3'b010; in_imm = 32'd20;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, in_ready); end
      checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h405203B3) begin
        failures++; $display("FAIL bp_hold[%0d]: got we=%b addr=%0d data=%08h, required 1/0/405203b3", i, imem_we, imem_addr, imem_wdata); end
      @(negedge clk);
    end
    imem_ready = 1'b1;
    push(0, 7'b0100011, 5'd0, 5'd2, 5'd9, 3'b010, 7'd0, 32'd20, 1'b1);
    wait_done();
    checks++; if (cap_addr.size() != 2) begin failures++; $display("FAIL bp_count: got %0d writes, required 2", cap_addr.size()); end
    else begin
      checks++; if (cap_addr[0] != 0 || cap_data[0] !== 32'h405203B3) begin failures++; $display("FAIL bp_w0: got %0d/%08h, required 0/405203b3", cap_addr[0], cap_data[0]); end
      checks++; if (cap_addr[1] != 4 || cap_data[1] !== 32'h00912A23) begin failures++; $display("FAIL bp_w1: got %0d/%08h, required 4/00912a23", cap_addr[1], cap_data[1]); end
    end
  endtask

  task automatic test_errors();
    cap_addr.delete(); cap_data.delete();
    do_start();
    push(0, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h2000, 1'b1);
    checks++; if (err !== 1'b1 || err_code !== 2'b10 || err_addr !== 10'd0) begin
      failures++; $display("FAIL range_2000: got err=%b code=%b addr=%0d, required 1/10/0", err, err_code, err_addr); end
    checks++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL range_nowrite: got we=%b in_ready=%b done=%b, required 0/0/0", imem_we, in_ready, done); end
    do_start();
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL start_clears_err: got %b/%b, required 0/00", err, err_code); end
    push(0, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
    push(0, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6, 1'b0);
    checks++; if (err !== 1'b1 || err_code !== 2'b10 || err_addr !== 10'd4) begin
      failures++; $display("FAIL range_6: got err=%b code=%b addr=%0d, required 1/10/4", err, err_code, err_addr); end
    repeat (3) @(negedge clk);
    checks++; if (cap_addr.size() != 1) begin failures++; $display("FAIL err_writes: got %0d writes, required 1", cap_addr.size()); end
    do_start();
    push(0, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5000, 1'b0);
    checks++; if (err !== 1'b1 || err_code !== 2'b01 || err_addr !== 10'd0) begin
      failures++; $display("FAIL bad_opcode: got err=%b code=%b addr=%0d, required 1/01/0", err, err_code, err_addr); end
  endtask

  task automatic test_overflow();
    s_cap_addr.delete();
    do_start();
    for (int i = 0; i < 5; i++)
      push(1, 7'b0110011, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, i == 4);
    checks++; if (s_err !== 1'b1 || s_err_code !== 2'b11 || s_err_addr !== 4'd12) begin
      failures++; $display("FAIL overflow: got err=%b code=%b addr=%0d, required 1/11/12", s_err, s_err_code, s_err_addr); end
    repeat (2) @(negedge clk);
    checks++; if (s_cap_addr.size() != 4) begin failures++; $display("FAIL ovf_count: got %0d writes, required 4", s_cap_addr.size()); end
    else begin
      checks++; if (s_cap_addr[0] != 0 || s_cap_addr[1] != 4 || s_cap_addr[2] != 8 || s_cap_addr[3] != 12) begin
        failures++; $display("FAIL ovf_addrs: got %0d,%0d,%0d,%0d, required 0,4,8,12", s_cap_addr[0], s_cap_addr[1], s_cap_addr[2], s_cap_addr[3]); end
    end
    checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL ovf_not_done: got %b, required 0", s_done); end
    do_start();
    checks++; if (s_err !== 1'b0 || s_busy !== 1'b1) begin failures++; $display("FAIL ovf_restart: got err=%b busy=%b, required 0/1", s_err, s_busy); end
    push(1, 7'b0110011, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    checks++; if (s_imem_we !== 1'b1 || s_imem_addr !== 4'd0) begin
      failures++; $display("FAIL ovf_restart_addr: got we=%b addr=%0d, required 1/0", s_imem_we, s_imem_addr); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b0;
    do_start();
    push(0, 7'b0110011, 5'd4, 5'd3, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    checks++; if (imem_we !== 1'b1) begin failures++; $display("FAIL pre_reset_pending: got %b, required 1", imem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin
      failures++; $display("FAIL async_reset_out: got we=%b addr=%0d data=%08h, required 0/0/0", imem_we, imem_addr, imem_wdata); end
    checks++; if ({in_ready, busy, done, err} !== 4'b0000 || err_code !== 2'b00) begin
      failures++; $display("FAIL async_reset_flags: got %b code=%b, required 0000/00", {in_ready, busy, done, err}, err_code); end
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    cap_addr.delete(); cap_data.delete();
    do_start();
    push(0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    wait_done();
    checks++; if (done !== 1'b1 || cap_addr.size() != 1) begin failures++; $display("FAIL post_reset_session: got done=%b writes=%0d, required 1/1", done, cap_addr.size()); end
    else begin
      checks++; if (cap_addr[0] != 0 || cap_data[0] !== 32'h002081B3) begin failures++; $display("FAIL post_reset_word: got %0d/%08h, required 0/002081b3", cap_addr[0], cap_data[0]); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_branch_jal();
    test_backpressure();
    test_errors();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
